sr_latch_ctrl: RTL

Round-robin sequencer that shares one `srlatch` instance among `N_REQ` requesters. Each granted requester gets exactly one set or clear operation, issued with setup/enable timing that guarantees the latch never sees `s=r=1`. After each operation the block reads back `q`, reports completion, and flags and counts mismatches. It sits between the requesting logic and the latch; no other block drives the latch's `control`/`s`/`r`.

---
 rtl/sr_latch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer sharing one SR latch among N_REQ requesters.
// Each grant issues one set/clear with setup-before-enable timing, then checks q.
module sr_latch_ctrl #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_cnt,
  output logic             latch_control,
  output logic             latch_s,
  output logic             latch_r,
  input  logic             latch_q
);

  localparam int unsigned MaxCyc = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned PtrW   = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StCheck} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [PtrW-1:0]   r_ptr, w_ptr_d;
  logic [PtrW-1:0]   w_sel, w_idx, w_sel_next;
  logic              w_found;
  logic              r_exp, w_exp_d;
  logic [N_REQ-1:0]  r_gnt, w_gnt_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_mismatch, w_mismatch_d;
  logic [7:0]        r_err_cnt, w_err_cnt_d;
  logic              r_ctrl, w_ctrl_d;
  logic              r_s, w_s_d;
  logic              r_r, w_r_d;
  logic              w_drive;

  // Cyclic priority search starting at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_idx = PtrW'((32'(r_ptr) + i) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_sel_next = (w_sel == PtrW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_ptr_d      = r_ptr;
    w_exp_d      = r_exp;
    w_gnt_d      = r_gnt;
    w_mismatch_d = 1'b0;
    w_err_cnt_d  = r_err_cnt;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StSetup;
          w_cnt_d   = '0;
          w_gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
          w_exp_d   = op[w_sel];
          w_ptr_d   = w_sel_next;
        end
      end
      StSetup: begin
        if (r_cnt == CntW'(SETUP_CYC - 1)) begin
          w_state_d = StPulse;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StPulse: begin
        if (r_cnt == CntW'(PULSE_CYC - 1)) begin
          // q is sampled on the edge that enters CHECK, after the full pulse.
          w_state_d    = StCheck;
          w_cnt_d      = '0;
          w_mismatch_d = (latch_q != r_exp);
          if ((latch_q != r_exp) && (r_err_cnt != 8'hFF)) begin
            w_err_cnt_d = r_err_cnt + 8'd1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StCheck: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
      end
    endcase

    // Latch-facing outputs are decoded from the next state and registered.
    w_drive  = (w_state_d == StSetup) || (w_state_d == StPulse);
    w_s_d    = w_drive & w_exp_d;
    w_r_d    = w_drive & ~w_exp_d;
    w_ctrl_d = (w_state_d == StPulse);
    w_busy_d = (w_state_d != StIdle);
    w_done_d = (w_state_d == StCheck);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_exp      <= 1'b0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
      r_ctrl     <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_ptr      <= w_ptr_d;
      r_exp      <= w_exp_d;
      r_gnt      <= w_gnt_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_mismatch <= w_mismatch_d;
      r_err_cnt  <= w_err_cnt_d;
      r_ctrl     <= w_ctrl_d;
      r_s        <= w_s_d;
      r_r        <= w_r_d;
    end
  end

  assign gnt           = r_gnt;
  assign busy          = r_busy;
  assign done          = r_done;
  assign mismatch      = r_mismatch;
  assign err_cnt       = r_err_cnt;
  assign latch_control = r_ctrl;
  assign latch_s       = r_s;
  assign latch_r       = r_r;

  a_no_sr: assert property (@(posedge clk) disable iff (!reset) !(latch_s && latch_r));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  a_ctrl_pulse: assert property (@(posedge clk) disable iff (!reset)
    latch_control |-> (r_state == StPulse) && (latch_s ^ latch_r));

endmodule
